mr_wb_arbiter: RTL

- Two-master, one-slave Wishbone B4 pipelined-mode arbiter.
- Shares the single data/memory bus between the instruction-fetch master (m0) and the load/store unit master (m1).
- Grant is round-robin per bus cycle (whole CYC assertion) with a registered grant state.
- Non-granted masters are stalled cleanly, so both masters' existing stb/stall handshakes work unmodified.

---
 rtl/mr_wb_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mr_wb_arbiter.sv
// ---------------------------------------------------------------------------
// mr_wb_arbiter
//
// Two-master, one-slave Wishbone B4 pipelined-mode arbiter. It shares one
// data/memory bus between the instruction-fetch master (m0) and the
// load/store master (m1). Ownership is decided once per bus cycle (a whole
// CYC assertion) and is held in a registered grant state. Round-robin
// tie-breaking uses a one-bit record of the most recent grant.
//
// The non-granted master always sees stall=1, ack=0 and err=0. It can
// therefore keep its strobe up with its normal stb/stall handshake until the
// bus is handed over.
//
// Parameters
//   XLEN       data width
//   XLEN_GRAN  number of dropped byte-address bits (word-granular address)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i         master N cycle, strobe, write enable
//   mN_addr_i                   master N word address [XLEN-XLEN_GRAN]
//   mN_sel_i                    master N byte selects [XLEN/8]
//   mN_dat_i                    master N write data
//   mN_ack_o/err_o/stall_o      responses routed to master N
//   mN_dat_o                    read data to master N (slave data, ungated)
//   s_cyc_o/stb_o/we_o          slave-side controls
//   s_addr_o/sel_o/dat_o        slave address, byte selects, write data
//   s_ack_i/err_i/stall_i       slave responses
//   s_dat_i                     slave read data
//   gnt_o                       one-hot current grant (debug / perf counters)
// ---------------------------------------------------------------------------
module mr_wb_arbiter #(
    parameter int XLEN      = 32,
    parameter int XLEN_GRAN = 2
) (
    input  logic                      clk,
    input  logic                      reset,

    // master 0 (instruction fetch)
    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [XLEN-XLEN_GRAN-1:0] m0_addr_i,
    input  logic [XLEN/8-1:0]         m0_sel_i,
    input  logic [XLEN-1:0]           m0_dat_i,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    output logic                      m0_stall_o,
    output logic [XLEN-1:0]           m0_dat_o,

    // master 1 (load/store unit)
    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [XLEN-XLEN_GRAN-1:0] m1_addr_i,
    input  logic [XLEN/8-1:0]         m1_sel_i,
    input  logic [XLEN-1:0]           m1_dat_i,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic                      m1_stall_o,
    output logic [XLEN-1:0]           m1_dat_o,

    // shared slave
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [XLEN-XLEN_GRAN-1:0] s_addr_o,
    output logic [XLEN/8-1:0]         s_sel_o,
    output logic [XLEN-1:0]           s_dat_o,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_stall_i,
    input  logic [XLEN-1:0]           s_dat_i,

    // debug
    output logic [1:0]                gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // 0 = m0 was granted most recently, 1 = m1. Resets to 1 so that m0 wins
    // the first tie after reset.
    logic last_gnt;
    logic last_gnt_next;

    // Read data fans out to both masters unqualified; only the routed ack
    // tells a master the data belongs to it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Grant state and round-robin history. A synchronous reset forces IDLE.
    // Because every slave-side output is decoded from this state, cyc/stb
    // drop on the same edge and any ack still in flight lands in IDLE, where
    // it is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
        end
    end

    // Next-state decode and the combinational bus mux.
    // Requests seen in IDLE are granted on the next edge, which gives one
    // cycle of arbitration latency. A granted master keeps the bus for as
    // long as it holds cyc, with no preemption. The cycle in which it drops
    // cyc is the release cycle. In that cycle a waiting master is handed the
    // bus directly, with no IDLE bubble. The muxed s_cyc_o is already low in
    // that cycle, so the slave sees a proper cycle boundary.
    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;

        s_cyc_o       = 1'b0;
        s_stb_o       = 1'b0;
        s_we_o        = 1'b0;
        s_addr_o      = '0;
        s_sel_o       = '0;
        s_dat_o       = '0;

        m0_ack_o      = 1'b0;
        m0_err_o      = 1'b0;
        m0_stall_o    = 1'b1;
        m1_ack_o      = 1'b0;
        m1_err_o      = 1'b0;
        m1_stall_o    = 1'b1;

        gnt_o         = 2'b00;

        case (state)
            IDLE: begin
                // On a tie, grant the master that was not granted last.
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last_gnt ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end

            GNT0: begin
                gnt_o      = 2'b01;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i;
                s_we_o     = m0_we_i;
                s_addr_o   = m0_addr_i;
                s_sel_o    = m0_sel_i;
                s_dat_o    = m0_dat_i;
                m0_stall_o = s_stall_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i;
                if (!m0_cyc_i) begin
                    state_next = m1_cyc_i ? GNT1 : IDLE;
                end
            end

            GNT1: begin
                gnt_o      = 2'b10;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i;
                s_we_o     = m1_we_i;
                s_addr_o   = m1_addr_i;
                s_sel_o    = m1_sel_i;
                s_dat_o    = m1_dat_i;
                m1_stall_o = s_stall_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i;
                if (!m1_cyc_i) begin
                    state_next = m0_cyc_i ? GNT0 : IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Record a grant only when it is newly entered. This covers the
        // grant from IDLE and the direct hand-over between masters.
        if (state_next == GNT0 && state != GNT0) begin
            last_gnt_next = 1'b0;
        end else if (state_next == GNT1 && state != GNT1) begin
            last_gnt_next = 1'b1;
        end
    end

endmodule
